cgra_config_loader: RTL
=======================

// Module: cgra_config_loader
// PURPOSE
// - Upstream feeder for the CGRA top-level config port (config_addr/config_data, one write per clock).
// - Accepts a 32-bit word stream (addr, data, addr, data, ...) from host/boot memory over valid/ready.
// - Buffers complete pairs in a FIFO and emits them as paced single-cycle config writes.
// - Idle cycles drive addr=0/data=0, which the CGRA treats as a no-op; raises done when the stream is fully drained.
// PARAMETERS
// - DEPTH  4   pair-FIFO entries; power of 2, >=2
// - GAP    0   idle (addr=0) cycles inserted after every emitted write; 0..255
// PORTS
// - clk_in             in   1   clock; all logic on rising edge
// - rst_n_in           in   1   reset, asynchronous assert, active-low
// - start_in           in   1   one-cycle pulse; arms a load from IDLE or DONE
// - in_valid           in   1   host word valid
// - in_ready           out  1   loader accepts word this cycle
// - in_data            in   32  host word: address when expecting addr, else data
// - in_last            in   1   marks final word of the stream; sampled with accepted word
// - config_addr_out    out  32  to CGRA config_addr_in; 0 when no write
// - config_data_out    out  32  to CGRA config_data_in; 0 when no write
// - done_out           out  1   sticky: stream consumed and FIFO drained
// - error_out          out  1   sticky: stream ended on an address word
// - pairs_written_out  out  16  count of writes emitted since last start; wraps at 2^16
// BEHAVIOUR
// - Reset: state IDLE, FIFO empty, expect_addr=1, GAP counter 0, all outputs 0 (in_ready=0).
// - Word accepted on rising edge with in_valid && in_ready.
// - States: IDLE -start_in-> LOAD -last accepted-> DRAIN -FIFO empty and no write pending-> DONE -start_in-> LOAD.
// - start_in outside IDLE/DONE is ignored. Entering LOAD clears done_out, error_out, pairs_written_out, expect_addr=1.
// - in_ready = (state==LOAD) && (expect_addr || !fifo_full); full is registered, so no push into a full FIFO
//   even with a same-cycle pop.
// - Addr word: latched to holding register; expect_addr toggles to 0. Data word: pushes {held_addr, data},
//   expect_addr toggles to 1.
// - in_last on a data word: pair pushed, then DRAIN. in_last on an addr word: address discarded,
//   error_out=1, then DRAIN (previously buffered pairs still emitted).
// - Emit: in LOAD/DRAIN, FIFO non-empty and GAP counter 0 -> pop; config_addr_out/config_data_out registered
//   with the pair for exactly one cycle; GAP counter loads GAP; pairs_written_out += 1.
//   All other cycles: both outputs 0; GAP counter decrements to 0.
// - Latency: data word accepted at edge N into an empty FIFO (counter 0) -> write visible from edge N+1 to N+2.
// - Order strictly preserved. Pairs with address 0 are forwarded unchanged (no-op at CGRA).
// - done_out rises on the edge after the final write's output cycle ends; outputs 0 while in DONE.
// - Reset mid-operation: FIFO and holding register flushed; no partial write is ever emitted.
// STRUCTURE
// - cgra_cfg_pkg: loader_state_e {IDLE, LOAD, DRAIN, DONE}; cfg_pair_t struct {addr[31:0], data[31:0]};
//   CFG_NOP_ADDR = 32'h0.
// - Sub-module cgra_cfg_fifo: synchronous FIFO of cfg_pair_t, DEPTH entries, registered full/empty,
//   async active-low reset.
// - Top: FSM, holding register, GAP counter, output register, write counter.
// TESTING
// - Reset: hold rst_n_in=0 -> in_ready=0, config_addr_out=0, config_data_out=0, done_out=0, error_out=0.
// - GAP=0, 3 pairs (1,A)(2,B)(3,C), last on C -> writes (1,A),(2,B),(3,C) one cycle after each data-word
//   accept; pairs_written_out=3; done_out=1.
// - DEPTH=4, GAP=7, 10 pairs, in_valid held high -> in_ready drops when FIFO full; 10 writes in order,
//   exactly 7 zero cycles between consecutive writes.
// - Words (5,E)(6) with in_last on address 6 -> single write (5,E); address 6 never on config_addr_out;
//   error_out=1, done_out=1.
// - Reset asserted in DRAIN with 3 pairs buffered -> outputs 0 immediately; after release state IDLE,
//   no further writes until start_in.
// - start_in pulsed in DONE -> done_out/error_out/pairs_written_out cleared, in_ready=1 next cycle;
//   second stream of 2 pairs emitted correctly.

Source files
------------

// File: rtl/cgra_cfg_pkg.sv
// Shared types for the CGRA configuration loader: FSM states and the buffered address/data pair.
package cgra_cfg_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} loader_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } cfg_pair_t;

  localparam logic [31:0] CFG_NOP_ADDR = 32'h0;
  localparam cfg_pair_t   CFG_NOP      = '{addr: CFG_NOP_ADDR, data: 32'h0};
endpackage

// File: rtl/cgra_config_loader_if.sv
// Host word stream into the loader: address and data words alternate, in_last tags the final word.
interface cgra_config_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/cgra_cfg_fifo.sv
// Pair FIFO with registered full/empty; pushes into a full FIFO and pops from an empty one are dropped.
module cgra_cfg_fifo
  import cgra_cfg_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  input  logic      push_i,
  input  cfg_pair_t push_dat_i,
  input  logic      pop_i,
  output cfg_pair_t pop_dat_o,
  output logic      full_o,
  output logic      empty_o
);
  localparam int unsigned    AW       = $clog2(DEPTH);
  localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]    CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);

  cfg_pair_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q, empty_q;
  logic          do_push, do_pop;

  assign do_push   = push_i && !full_q;
  assign do_pop    = pop_i && !empty_q;
  assign pop_dat_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + CNT_ONE;
    else if (do_pop && !do_push) cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CNT_FULL);
      empty_q <= (cnt_d == '0);
    end
  end

  // Storage needs no reset: entries are only read behind a non-empty count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end
endmodule

// File: rtl/cgra_config_loader.sv
// Pairs host addr/data words, buffers them and emits one paced config write per pop,
// with GAP idle (all-zero) cycles after each write; done/error are sticky until the next start.
module cgra_config_loader
  import cgra_cfg_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned GAP   = 0
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 start_in,
  cgra_config_loader_if.slave  host,
  output logic [31:0]          config_addr_out,
  output logic [31:0]          config_data_out,
  output logic                 done_out,
  output logic                 error_out,
  output logic [15:0]          pairs_written_out
);
  localparam logic [7:0] GAP_LOAD = 8'(GAP);

  loader_state_e state_q, state_d;
  logic          expect_addr_q, expect_addr_d;
  logic [31:0]   held_addr_q, held_addr_d;
  logic [7:0]    gap_cnt_q, gap_cnt_d;
  cfg_pair_t     out_q, out_d;
  logic          out_vld_q, out_vld_d;
  logic [15:0]   pairs_q, pairs_d;
  logic          done_q, done_d, error_q, error_d;

  cfg_pair_t     fifo_head;
  logic          fifo_full, fifo_empty;
  logic          accept, push, pop;

  assign host.in_ready = (state_q == LOAD) && (expect_addr_q || !fifo_full);
  assign accept        = host.in_valid && host.in_ready;
  assign push          = accept && !expect_addr_q;
  assign pop           = ((state_q == LOAD) || (state_q == DRAIN)) && !fifo_empty
                         && (gap_cnt_q == 8'd0);

  cgra_cfg_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i      (clk_in),
    .rst_n_i    (rst_n_in),
    .push_i     (push),
    .push_dat_i ('{addr: held_addr_q, data: host.in_data}),
    .pop_i      (pop),
    .pop_dat_o  (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    expect_addr_d = expect_addr_q;
    held_addr_d   = held_addr_q;
    gap_cnt_d     = gap_cnt_q;
    pairs_d       = pairs_q;
    done_d        = done_q;
    error_d       = error_q;
    out_d         = CFG_NOP;
    out_vld_d     = 1'b0;

    if (pop) begin
      out_d     = fifo_head;
      out_vld_d = 1'b1;
      gap_cnt_d = GAP_LOAD;
      pairs_d   = pairs_q + 16'd1;
    end else if (gap_cnt_q != 8'd0) begin
      gap_cnt_d = gap_cnt_q - 8'd1;
    end

    if (accept) begin
      expect_addr_d = !expect_addr_q;
      if (expect_addr_q) held_addr_d = host.in_data;
      // A stream ending on an address word drops that address and flags the truncation.
      if (host.in_last) begin
        state_d       = DRAIN;
        expect_addr_d = 1'b1;
        if (expect_addr_q) error_d = 1'b1;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start_in) begin
          state_d       = LOAD;
          expect_addr_d = 1'b1;
          done_d        = 1'b0;
          error_d       = 1'b0;
          pairs_d       = 16'd0;
        end
      end
      // Wait for the last write's output cycle to finish before reporting done.
      DRAIN: begin
        if (fifo_empty && !out_vld_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= IDLE;
      expect_addr_q <= 1'b1;
      held_addr_q   <= 32'h0;
      gap_cnt_q     <= 8'd0;
      out_q         <= CFG_NOP;
      out_vld_q     <= 1'b0;
      pairs_q       <= 16'd0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      expect_addr_q <= expect_addr_d;
      held_addr_q   <= held_addr_d;
      gap_cnt_q     <= gap_cnt_d;
      out_q         <= out_d;
      out_vld_q     <= out_vld_d;
      pairs_q       <= pairs_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  assign config_addr_out   = out_q.addr;
  assign config_data_out   = out_q.data;
  assign done_out          = done_q;
  assign error_out         = error_q;
  assign pairs_written_out = pairs_q;
endmodule
